// File: rtl/cam_alloc_ctrl_pkg.sv
// Shared types and default sizing for the CAM allocation controller.
package cam_pkg;

    localparam int CAM_SIZE  = 5;
    localparam int CAM_KEY_W = 32;

    typedef enum logic {
        OP_INSERT = 1'b0,
        OP_DELETE = 1'b1
    } cam_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_RESP  = 2'd2
    } cam_state_e;

endpackage

// File: rtl/cam_alloc_ctrl_if.sv
// Request/response handshake, CAM write port and occupancy status of the allocator.
interface cam_alloc_ctrl_if #(
    parameter int SIZE  = 5,
    parameter int KEY_W = 32
);
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic                 req_op_i;
    logic [KEY_W-1:0]     req_key_i;
    logic [SIZE-1:0]      req_idx_i;

    logic [SIZE-1:0]      dec_addr_o;
    logic                 dec_en_o;
    logic [KEY_W-1:0]     wr_key_o;
    logic                 wr_vld_o;

    logic                 resp_valid_o;
    logic                 resp_ready_i;
    logic [SIZE-1:0]      resp_idx_o;
    logic                 resp_err_o;

    logic [2**SIZE-1:0]   valid_map_o;
    logic [SIZE:0]        count_o;
    logic                 full_o;
    logic                 empty_o;

    // Controller side
    modport slave (
        input  req_valid_i, req_op_i, req_key_i, req_idx_i, resp_ready_i,
        output req_ready_o, dec_addr_o, dec_en_o, wr_key_o, wr_vld_o,
               resp_valid_o, resp_idx_o, resp_err_o,
               valid_map_o, count_o, full_o, empty_o
    );

    // Requester side
    modport master (
        output req_valid_i, req_op_i, req_key_i, req_idx_i, resp_ready_i,
        input  req_ready_o, dec_addr_o, dec_en_o, wr_key_o, wr_vld_o,
               resp_valid_o, resp_idx_o, resp_err_o,
               valid_map_o, count_o, full_o, empty_o
    );
endinterface

// File: rtl/cam_alloc_ctrl_ffz.sv
// Find-first-zero: lowest index whose bit is clear, plus an all-ones flag.
module cam_ffz #(
    parameter int SIZE = 5
) (
    input  logic [2**SIZE-1:0] vec_i,
    output logic [SIZE-1:0]    idx_o,
    output logic               all_ones_o
);

    // Scan from the top down so the lowest clear bit wins.
    always_comb begin
        idx_o      = '0;
        all_ones_o = &vec_i;
        for (int i = 2**SIZE - 1; i >= 0; i--) begin
            if (!vec_i[i]) idx_o = SIZE'(i);
        end
    end

endmodule

// File: rtl/cam_alloc_ctrl.sv
// CAM entry allocator: one request in flight, IDLE -> (WRITE) -> RESP.
//   state    | meaning
//   ST_IDLE  | ready for a request
//   ST_WRITE | one-cycle CAM write strobe to the target entry
//   ST_RESP  | response held until the requester takes it
module cam_alloc_ctrl
    import cam_pkg::*;
#(
    parameter int SIZE  = CAM_SIZE,
    parameter int KEY_W = CAM_KEY_W
) (
    input logic            clk_i,
    input logic            rst_ni,
    cam_alloc_ctrl_if.slave bus
);

    localparam int            N        = 2**SIZE;
    localparam logic [SIZE:0] FULL_CNT = {1'b1, {SIZE{1'b0}}};

    cam_state_e       state;
    cam_op_e          op_q;
    logic [SIZE-1:0]  tgt_q;
    logic [N-1:0]     map_q;
    logic [SIZE:0]    count_q;
    logic             ready_q;
    logic             dec_en_q;
    logic [SIZE-1:0]  dec_addr_q;
    logic [KEY_W-1:0] wr_key_q;
    logic             wr_vld_q;
    logic             resp_valid_q;
    logic [SIZE-1:0]  resp_idx_q;
    logic             resp_err_q;

    logic [SIZE-1:0]  free_idx;
    logic             map_full;
    cam_op_e          req_op;

    assign req_op = cam_op_e'(bus.req_op_i);

    cam_ffz #(.SIZE(SIZE)) u_ffz (
        .vec_i      (map_q),
        .idx_o      (free_idx),
        .all_ones_o (map_full)
    );

    // Sequencing FSM with all datapath and status registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state        <= ST_IDLE;
            op_q         <= OP_INSERT;
            tgt_q        <= '0;
            map_q        <= '0;
            count_q      <= '0;
            ready_q      <= 1'b1;
            dec_en_q     <= 1'b0;
            dec_addr_q   <= '0;
            wr_key_q     <= '0;
            wr_vld_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_idx_q   <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid_i) begin
                        ready_q <= 1'b0;
                        op_q    <= req_op;
                        if (req_op == OP_INSERT && map_full) begin
                            state        <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_idx_q   <= '0;
                        end else if (req_op == OP_INSERT) begin
                            state      <= ST_WRITE;
                            tgt_q      <= free_idx;
                            dec_en_q   <= 1'b1;
                            dec_addr_q <= free_idx;
                            wr_key_q   <= bus.req_key_i;
                            wr_vld_q   <= 1'b1;
                        end else if (map_q[bus.req_idx_i]) begin
                            state      <= ST_WRITE;
                            tgt_q      <= bus.req_idx_i;
                            dec_en_q   <= 1'b1;
                            dec_addr_q <= bus.req_idx_i;
                            wr_key_q   <= '0;
                            wr_vld_q   <= 1'b0;
                        end else begin
                            state        <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_idx_q   <= bus.req_idx_i;
                        end
                    end
                end
                ST_WRITE: begin
                    state        <= ST_RESP;
                    dec_en_q     <= 1'b0;
                    dec_addr_q   <= '0;
                    wr_key_q     <= '0;
                    wr_vld_q     <= 1'b0;
                    map_q[tgt_q] <= (op_q == OP_INSERT);
                    if (op_q == OP_INSERT && count_q != FULL_CNT)
                        count_q <= count_q + 1'b1;
                    else if (op_q == OP_DELETE && count_q != '0)
                        count_q <= count_q - 1'b1;
                    resp_valid_q <= 1'b1;
                    resp_idx_q   <= tgt_q;
                    resp_err_q   <= 1'b0;
                end
                ST_RESP: begin
                    if (bus.resp_ready_i) begin
                        state        <= ST_IDLE;
                        ready_q      <= 1'b1;
                        resp_valid_q <= 1'b0;
                        resp_idx_q   <= '0;
                        resp_err_q   <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Handshake and strobe outputs are masked while reset is low so an
    // in-flight write or response is dropped within the reset cycle.
    assign bus.req_ready_o  = ready_q & rst_ni;
    assign bus.dec_en_o     = dec_en_q & rst_ni;
    assign bus.dec_addr_o   = rst_ni ? dec_addr_q : '0;
    assign bus.wr_key_o     = rst_ni ? wr_key_q : '0;
    assign bus.wr_vld_o     = wr_vld_q & rst_ni;
    assign bus.resp_valid_o = resp_valid_q & rst_ni;
    assign bus.resp_idx_o   = rst_ni ? resp_idx_q : '0;
    assign bus.resp_err_o   = resp_err_q & rst_ni;

    assign bus.valid_map_o  = map_q;
    assign bus.count_o      = count_q;
    assign bus.full_o       = (count_q == FULL_CNT);
    assign bus.empty_o      = (count_q == '0);

endmodule

// File: tb/tb_cam_alloc_ctrl.sv
// Directed plus random bench for cam_alloc_ctrl against an occupancy-array model.
module tb_cam_alloc_ctrl;

    localparam int SIZE  = 5;
    localparam int KEY_W = 32;
    localparam int N     = 2**SIZE;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    bit   mdl_map [N];
    int   mdl_cnt;

    always #5 clk = ~clk;

    cam_alloc_ctrl_if #(.SIZE(SIZE), .KEY_W(KEY_W)) bus ();

    cam_alloc_ctrl #(.SIZE(SIZE), .KEY_W(KEY_W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial begin
        #3000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] mdl_vec();
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i] = mdl_map[i];
        return v;
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < N; i++) mdl_map[i] = 1'b0;
        mdl_cnt = 0;
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_map"},   64'(bus.valid_map_o), 64'(mdl_vec()));
        chk({tag, "_count"}, 64'(bus.count_o), 64'(mdl_cnt));
        chk({tag, "_full"},  64'(bus.full_o), 64'(mdl_cnt == N));
        chk({tag, "_empty"}, 64'(bus.empty_o), 64'(mdl_cnt == 0));
    endtask

    // One request, start to finish; hold > 0 keeps resp_ready low that many cycles
    // while a second request is waiting.
    task automatic transact(input string tag, input bit op, input logic [KEY_W-1:0] key,
                            input logic [SIZE-1:0] idx, input int hold);
        bit               exp_err;
        bit               exp_strobe;
        int               exp_idx;
        int               n;
        int               strobes;
        logic [SIZE-1:0]  s_addr;
        logic [KEY_W-1:0] s_key;
        logic             s_vld;
        logic [SIZE-1:0]  r_idx;
        logic             r_err;

        exp_idx = 0;
        if (op == 1'b0) begin
            if (mdl_cnt == N) begin
                exp_err = 1'b1; exp_strobe = 1'b0; exp_idx = 0;
            end else begin
                for (int i = N - 1; i >= 0; i--) if (!mdl_map[i]) exp_idx = i;
                exp_err = 1'b0; exp_strobe = 1'b1;
                mdl_map[exp_idx] = 1'b1;
                mdl_cnt++;
            end
        end else begin
            exp_idx = int'(idx);
            if (mdl_map[idx]) begin
                exp_err = 1'b0; exp_strobe = 1'b1;
                mdl_map[idx] = 1'b0;
                mdl_cnt--;
            end else begin
                exp_err = 1'b1; exp_strobe = 1'b0;
            end
        end

        @(negedge clk);
        chk({tag, "_ready"}, 64'(bus.req_ready_o), 64'd1);
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = op;
        bus.req_key_i   = key;
        bus.req_idx_i   = idx;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        n = 1;
        strobes = 0;
        s_addr = '0; s_key = '0; s_vld = 1'b0;
        while (!bus.resp_valid_o && n < 10) begin
            if (bus.dec_en_o) begin
                strobes++;
                s_addr = bus.dec_addr_o; s_key = bus.wr_key_o; s_vld = bus.wr_vld_o;
            end
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 64'(n), exp_err ? 64'd1 : 64'd2);
        chk({tag, "_strobes"}, 64'(strobes), 64'(exp_strobe));
        if (exp_strobe) begin
            chk({tag, "_dec_addr"}, 64'(s_addr), 64'(exp_idx));
            chk({tag, "_wr_key"},   64'(s_key), op ? 64'd0 : 64'(key));
            chk({tag, "_wr_vld"},   64'(s_vld), op ? 64'd0 : 64'd1);
        end
        chk({tag, "_resp_idx"}, 64'(bus.resp_idx_o), 64'(exp_idx));
        chk({tag, "_resp_err"}, 64'(bus.resp_err_o), 64'(exp_err));
        chk({tag, "_dec_en_idle"}, 64'(bus.dec_en_o), 64'd0);
        chk_status(tag);

        if (hold > 0) begin
            r_idx = bus.resp_idx_o;
            r_err = bus.resp_err_o;
            bus.req_valid_i = 1'b1;
            bus.req_op_i    = 1'b0;
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                chk({tag, "_hold_valid"}, 64'(bus.resp_valid_o), 64'd1);
                chk({tag, "_hold_idx"},   64'(bus.resp_idx_o), 64'(r_idx));
                chk({tag, "_hold_err"},   64'(bus.resp_err_o), 64'(r_err));
                chk({tag, "_hold_ready"}, 64'(bus.req_ready_o), 64'd0);
                chk({tag, "_hold_dec"},   64'(bus.dec_en_o), 64'd0);
            end
            bus.req_valid_i = 1'b0;
            chk_status({tag, "_hold"});
        end

        bus.resp_ready_i = 1'b1;
        @(negedge clk);
        bus.resp_ready_i = 1'b0;
        chk({tag, "_resp_done"}, 64'(bus.resp_valid_o), 64'd0);
    endtask

    initial begin
        logic [KEY_W-1:0] k;
        bus.req_valid_i  = 1'b0;
        bus.req_op_i     = 1'b0;
        bus.req_key_i    = '0;
        bus.req_idx_i    = '0;
        bus.resp_ready_i = 1'b0;
        mdl_reset();

        repeat (3) @(negedge clk);
        chk("rst_ready",      64'(bus.req_ready_o), 64'd0);
        chk("rst_dec_en",     64'(bus.dec_en_o), 64'd0);
        chk("rst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
        chk_status("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'(bus.req_ready_o), 64'd1);

        transact("del_empty", 1'b1, '0, 5'd3, 0);
        transact("ins_first", 1'b0, 32'hDEADBEEF, '0, 0);
        for (int i = 1; i < N; i++) transact("ins_fill", 1'b0, $urandom, $urandom, 0);
        chk("full_after_fill", 64'(bus.full_o), 64'd1);
        transact("ins_full", 1'b0, 32'h12345678, '0, 0);
        transact("del_7", 1'b1, '0, 5'd7, 0);
        transact("ins_reuse", 1'b0, 32'hCAFEF00D, '0, 0);
        chk("count_32", 64'(bus.count_o), 64'd32);
        transact("hold", 1'b1, '0, 5'd10, 5);

        for (int t = 0; t < 400; t++) begin
            k = $urandom;
            transact("rand", 1'($urandom_range(0, 1)), k, SIZE'($urandom_range(0, N - 1)), 0);
        end

        // Reset asserted during the write strobe.
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        if (mdl_cnt < N) begin
            bus.req_op_i = 1'b0;
        end else begin
            bus.req_op_i  = 1'b1;
            bus.req_idx_i = '0;
        end
        bus.req_key_i = 32'hA5A5A5A5;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rstw_strobe", 64'(bus.dec_en_o), 64'd0);
        chk("rstw_ready",  64'(bus.req_ready_o), 64'd0);
        @(negedge clk);
        mdl_reset();
        chk("rstw_resp_valid", 64'(bus.resp_valid_o), 64'd0);
        chk_status("rstw");
        rst_n = 1'b1;
        transact("ins_after_rst", 1'b0, 32'h0BADF00D, '0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cam_alloc_ctrl.md
CAM_ALLOC_CTRL -- requirements
Module: cam_alloc_ctrl

Interface
REQ-001 SHALL have parameter SIZE, default 5: entry-index width; the CAM holds 2**SIZE entries.
REQ-002 SHALL have parameter KEY_W, default 32: key width written into a CAM entry.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port req_valid_i, input, 1 bit: a request is present.
REQ-006 SHALL have port req_ready_o, output, 1 bit: the controller accepts a request this cycle.
REQ-007 SHALL have port req_op_i, input, 1 bit: 0 = INSERT, 1 = DELETE.
REQ-008 SHALL have port req_key_i, input, KEY_W bits: key for INSERT.
REQ-009 SHALL have port req_idx_i, input, SIZE bits: entry index for DELETE.
REQ-010 SHALL have port dec_addr_o, output, SIZE bits: entry index driven to the CAM write decoder.
REQ-011 SHALL have port dec_en_o, output, 1 bit: decoder enable, i.e. the one-cycle write strobe.
REQ-012 SHALL have port wr_key_o, output, KEY_W bits: key data written into the entry.
REQ-013 SHALL have port wr_vld_o, output, 1 bit: entry valid bit written with the key (1 = INSERT, 0 = DELETE).
REQ-014 SHALL have ports resp_valid_o (output), resp_ready_i (input), 1 bit each: response handshake.
REQ-015 SHALL have ports resp_idx_o (output, SIZE bits) and resp_err_o (output, 1 bit): index affected and error flag.
REQ-016 SHALL have ports valid_map_o (output, 2**SIZE bits), count_o (output, SIZE+1 bits), full_o (output, 1 bit) and empty_o (output, 1 bit): occupancy.

Function
REQ-017 SHALL implement FSM states IDLE, WRITE and RESP.
REQ-018 IDLE: req_ready_o = 1; a request is accepted when req_valid_i & req_ready_o, capturing op, key and idx into registers.
REQ-019 Accepted INSERT, not full: SHALL allocate the lowest-numbered index whose valid_map bit is 0, then go to WRITE.
REQ-020 Accepted INSERT while full_o = 1: SHALL go directly to RESP with resp_err_o = 1, resp_idx_o = 0, no strobe.
REQ-021 Accepted DELETE of an entry whose valid_map bit is 1: SHALL go to WRITE. DELETE of an invalid entry: SHALL go to RESP with resp_err_o = 1, resp_idx_o = req_idx_i, no strobe.
REQ-022 WRITE lasts exactly one cycle and then goes to RESP. During it: dec_en_o = 1, dec_addr_o = target index, wr_key_o = captured key (all zero for DELETE), wr_vld_o = 1 for INSERT and 0 for DELETE.
REQ-023 valid_map_o bit, count_o, full_o and empty_o SHALL update on the WRITE-to-RESP edge and be visible in the first RESP cycle.
REQ-024 RESP: resp_valid_o = 1; SHALL hold resp_idx_o and resp_err_o stable until resp_ready_i = 1, then return to IDLE.
REQ-025 req_ready_o SHALL be 0 in WRITE and RESP; only one request is in flight. Accept-to-resp_valid latency is 2 cycles on success, 1 cycle on error.
REQ-026 dec_en_o SHALL be 0 outside WRITE; dec_addr_o and wr_key_o SHALL be 0 when dec_en_o = 0.
REQ-027 full_o = (count_o == 2**SIZE); empty_o = (count_o == 0). count_o SHALL never wrap past 2**SIZE or below 0.

Reset
REQ-028 While rst_ni = 0 at a clock edge: state = IDLE; valid_map_o = 0; count_o = 0; empty_o = 1; all other outputs 0 except req_ready_o.
REQ-029 req_ready_o SHALL be 0 while rst_ni = 0.
REQ-030 Reset during WRITE or RESP SHALL abort the operation: no response is issued, and a strobe in the reset cycle is suppressed.

Structure
REQ-031 The shared package cam_pkg SHALL hold the op enum (OP_INSERT, OP_DELETE), the FSM state enum and the CAM_SIZE/CAM_KEY_W constants.
REQ-032 The lowest-free-index search SHALL be a sub-module, cam_ffz (find-first-zero, 2**SIZE inputs, SIZE-bit index plus all-ones flag).

Verification
REQ-033 After reset, INSERT key 0xDEADBEEF -> one dec_en_o pulse with dec_addr_o = 0, wr_vld_o = 1; then resp_idx_o = 0, resp_err_o = 0, count_o = 1.
REQ-034 32 back-to-back INSERTs -> indices 0..31 in order; full_o = 1; a 33rd INSERT -> resp_err_o = 1 with no dec_en_o pulse.
REQ-035 Full table, DELETE idx 7 then INSERT -> the DELETE strobes addr 7 with wr_vld_o = 0; the INSERT is allocated idx 7; count_o returns to 32.
REQ-036 DELETE idx 3 on an empty table -> resp_err_o = 1, resp_idx_o = 3, valid_map_o unchanged, empty_o = 1.
REQ-037 resp_ready_i held 0 for 5 cycles -> resp_valid_o/idx/err stable, req_ready_o = 0, a pending req_valid_i is not accepted.
REQ-038 rst_ni driven low in the WRITE cycle -> no resp_valid_o, valid_map_o = 0, count_o = 0 on the next cycle.
